// File: rtl/simple_mem_responder.sv
// simple_mem_responder
//   Memory-side responder below the direct-mapped cache: 32 x 32-bit word RAM
//   with a valid/ready request and response handshake and a fixed, programmable
//   access latency that models slow main memory. One request is outstanding at
//   a time. A read returns mem[addr]. A write stores the word and returns the
//   stored value as its acknowledge.
//
//   Optional build macro: MEM_BYTE_MASK_EN adds req_be[3:0] for byte-masked writes.
//
// Parameters
//   LATENCY : cycles from the request accept edge to the first edge at which
//             resp_valid is sampled high (1..15)
//   DEPTH   : number of words, fixed at 32 to match the 5-bit address
//
// Ports
//   clk, rst_n           : clock and synchronous active-low reset
//   req_valid/req_ready  : request handshake; ready only while idle
//   req_wr/addr/data     : request kind, word address and write data
//   req_be               : byte enables (MEM_BYTE_MASK_EN builds only)
//   resp_valid/resp_ready: response handshake
//   resp_wr/resp_data    : write-ack flag and read data or the stored word
//   busy                 : a request is in flight or its response is pending
module simple_mem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_data,
`ifdef MEM_BYTE_MASK_EN
  input  logic [3:0]  req_be,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_wr,
  output logic [31:0] resp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_wr;
  logic [4:0]  lat_addr;
  logic [31:0] lat_data;
  logic [3:0]  lat_be;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        access;
  logic [3:0]  in_be;
  logic        acc_wr;
  logic [4:0]  acc_addr;
  logic [31:0] acc_data;
  logic [3:0]  acc_be;
  logic [31:0] old_word;
  logic [31:0] merged;

`ifdef MEM_BYTE_MASK_EN
  assign in_be = req_be;
`else
  assign in_be = 4'hF;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY > 1) begin
            state_nxt = WAIT;
          end else begin
            state_nxt = RESP;
            access    = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the access happens on the accept edge itself, before the
  // request latches hold anything, so the live request fields are used then.
  always_comb begin
    if (state == IDLE) begin
      acc_wr   = req_wr;
      acc_addr = req_addr;
      acc_data = req_data;
      acc_be   = in_be;
    end else begin
      acc_wr   = lat_wr;
      acc_addr = lat_addr;
      acc_data = lat_data;
      acc_be   = lat_be;
    end
  end

  assign old_word = mem[acc_addr];

  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (acc_be[i]) merged[8*i +: 8] = acc_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_be    <= '0;
      resp_wr   <= 1'b0;
      resp_data <= '0;
      mem       <= '{default: '0};
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_wr   <= req_wr;
        lat_addr <= req_addr;
        lat_data <= req_data;
        lat_be   <= in_be;
        cnt      <= CNT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        resp_wr <= acc_wr;
        if (acc_wr) begin
          mem[acc_addr] <= merged;
          resp_data     <= merged;
        end else begin
          resp_data <= old_word;
        end
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_simple_mem_responder.sv
module tb_simple_mem_responder;

  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_wr;
  logic [4:0]  a_req_addr;
  logic [31:0] a_req_data;
  logic        a_resp_valid, a_resp_ready, a_resp_wr, a_busy;
  logic [31:0] a_resp_data;

  logic        b_req_valid, b_req_ready, b_req_wr;
  logic [4:0]  b_req_addr;
  logic [31:0] b_req_data;
  logic        b_resp_valid, b_resp_ready, b_resp_wr, b_busy;
  logic [31:0] b_resp_data;
`ifdef MEM_BYTE_MASK_EN
  logic [3:0]  a_req_be;
  logic [3:0]  b_req_be;
`endif

  simple_mem_responder #(.LATENCY(LAT_A), .DEPTH(32)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(a_req_wr),
    .req_addr(a_req_addr), .req_data(a_req_data),
`ifdef MEM_BYTE_MASK_EN
    .req_be(a_req_be),
`endif
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_wr(a_resp_wr),
    .resp_data(a_resp_data), .busy(a_busy)
  );

  simple_mem_responder #(.LATENCY(LAT_B), .DEPTH(32)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
    .req_addr(b_req_addr), .req_data(b_req_data),
`ifdef MEM_BYTE_MASK_EN
    .req_be(b_req_be),
`endif
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_wr(b_resp_wr),
    .resp_data(b_resp_data), .busy(b_busy)
  );

  int unsigned pass_cnt  = 0;
  int unsigned check_cnt = 0;

  logic [31:0] model_mem [32];

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference memory behaviour: a write replaces the enabled bytes of the old word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  function automatic logic [3:0] eff_be(input logic [3:0] be);
`ifdef MEM_BYTE_MASK_EN
    return be;
`else
    return 4'hF;
`endif
  endfunction

  function automatic logic [31:0] exp_of(input logic wr, input logic [4:0] addr,
                                         input logic [31:0] data, input logic [3:0] be);
    return wr ? merge(model_mem[addr], data, eff_be(be)) : model_mem[addr];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ":req_ready"},  32'(a_req_ready),  32'd1);
    chk({tag, ":resp_valid"}, 32'(a_resp_valid), 32'd0);
    chk({tag, ":resp_wr"},    32'(a_resp_wr),    32'd0);
    chk({tag, ":resp_data"},  a_resp_data,       32'd0);
    chk({tag, ":busy"},       32'(a_busy),       32'd0);
  endtask

  // One full transaction on instance A, timed and checked, then the model is updated.
  task automatic do_req(input string nm, input logic wr, input logic [4:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        input logic [31:0] exp, input int unsigned stall);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!a_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ":req_ready"}, 32'(a_req_ready), 32'd1);
    a_req_valid  = 1'b1;
    a_req_wr     = wr;
    a_req_addr   = addr;
    a_req_data   = data;
`ifdef MEM_BYTE_MASK_EN
    a_req_be     = be;
`endif
    a_resp_ready = (stall == 0);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_wr    = 1'($urandom);
    a_req_addr  = 5'($urandom);
    a_req_data  = $urandom;
    n = 1;
    while (!a_resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ":latency"},   32'(n),            32'(LAT_A));
    chk({nm, ":resp_data"}, a_resp_data,       exp);
    chk({nm, ":resp_wr"},   32'(a_resp_wr),    32'(wr));
    chk({nm, ":busy_ready"}, {30'd0, a_busy, a_req_ready}, 32'd2);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      chk({nm, ":stall_valid"}, 32'(a_resp_valid), 32'd1);
      chk({nm, ":stall_data"},  a_resp_data,       exp);
      a_resp_ready = 1'b1;
    end
    @(negedge clk);
    chk({nm, ":idle_after"}, {30'd0, a_resp_valid, a_req_ready}, 32'd1);
    a_resp_ready = 1'b0;
    if (wr) model_mem[addr] = merge(model_mem[addr], data, eff_be(be));
  endtask

  task automatic b_write(input logic [4:0] addr, input logic [31:0] data);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!b_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    b_req_valid  = 1'b1;
    b_req_wr     = 1'b1;
    b_req_addr   = addr;
    b_req_data   = data;
    b_resp_ready = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b0;
    n = 1;
    while (!b_resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_preload_ack", b_resp_data, data);
    @(negedge clk);
    b_resp_ready = 1'b0;
  endtask

  task automatic stall_test();
    logic [4:0]  used [$];
    int unsigned n;
    @(negedge clk);
    a_req_valid  = 1'b1;
    a_req_wr     = 1'b0;
    a_req_addr   = 5'd31;
    a_resp_ready = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b0;
    n = 1;
    while (!a_resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall:latency", 32'(n), 32'(LAT_A));
    for (int i = 0; i < 10; i++) begin
      a_req_valid = 1'($urandom);
      a_req_wr    = 1'b1;
      a_req_addr  = 5'($urandom);
      a_req_data  = $urandom;
      used.push_back(a_req_addr);
      @(negedge clk);
      chk("stall:resp_valid", 32'(a_resp_valid), 32'd1);
      chk("stall:resp_data",  a_resp_data,       32'hDEADBEEF);
      chk("stall:req_ready",  32'(a_req_ready),  32'd0);
    end
    a_req_valid  = 1'b0;
    a_resp_ready = 1'b1;
    @(negedge clk);
    chk("stall:release", {30'd0, a_resp_valid, a_req_ready}, 32'd1);
    a_resp_ready = 1'b0;
    @(negedge clk);
    chk("stall:no_accept", {30'd0, a_resp_valid, a_busy}, 32'd0);
    foreach (used[i]) do_req("stall_readback", 1'b0, used[i], '0, 4'hF, model_mem[used[i]], 0);
  endtask

  task automatic reset_test();
    @(negedge clk);
    a_req_valid  = 1'b1;
    a_req_wr     = 1'b1;
    a_req_addr   = 5'd3;
    a_req_data   = 32'h12345678;
`ifdef MEM_BYTE_MASK_EN
    a_req_be     = 4'hF;
`endif
    a_resp_ready = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("rst_mid:in_wait", {30'd0, a_busy, a_resp_valid}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_a("rst_mid");
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid:no_resp", 32'(a_resp_valid), 32'd0);
    end
    do_req("rst_mid_read3", 1'b0, 5'd3, '0, 4'hF, 32'd0, 0);
  endtask

  task automatic b2b_test();
    int acc_c [4];
    int nacc;
    int nresp;
    nacc  = 0;
    nresp = 0;
    for (int i = 0; i < 4; i++) acc_c[i] = 0;
    for (int i = 0; i < 4; i++) b_write(5'(i), 32'(32'h10 + i));
    b_resp_ready = 1'b1;
    b_req_wr     = 1'b0;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      @(negedge clk);
      if (b_resp_valid) begin
        chk("b2b:data",    b_resp_data, 32'(32'h10 + nresp));
        chk("b2b:latency", 32'(c - acc_c[nresp]), 32'(LAT_B));
        nresp++;
      end
      if (b_req_ready && nacc < 4) begin
        if (nacc > 0) chk("b2b:spacing", 32'(c - acc_c[nacc-1]), 32'(LAT_B + 1));
        b_req_valid = 1'b1;
        b_req_addr  = 5'(nacc);
        acc_c[nacc] = c;
        nacc++;
      end else begin
        b_req_valid = 1'b0;
      end
    end
    b_req_valid = 1'b0;
    chk("b2b:responses", 32'(nresp), 32'd4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;

    tbl[0] = '{1'b0, 5'd5,  32'h0,        4'hF, 32'h0};
    tbl[1] = '{1'b1, 5'd31, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 5'd31, 32'h0,        4'hF, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 5'd0,  32'h0,        4'hF, 32'h0};
    tbl[4] = '{1'b1, 5'd0,  32'hCAFEF00D, 4'hF, 32'hCAFEF00D};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        4'hF, 32'hCAFEF00D};
    tbl[6] = '{1'b0, 5'd31, 32'h0,        4'hF, 32'hDEADBEEF};

    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = '0; a_req_data = '0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_data = '0; b_resp_ready = 1'b0;
`ifdef MEM_BYTE_MASK_EN
    a_req_be = 4'hF;
    b_req_be = 4'hF;
`endif
    model_clear();
    repeat (3) @(negedge clk);
    chk_reset_a("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      do_req($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].exp, 0);

    stall_test();
    reset_test();

    for (int i = 0; i < 60; i++) begin
      wr   = 1'($urandom);
      addr = 5'($urandom);
      data = $urandom;
      be   = 4'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req("rand", wr, addr, data, be, exp_of(wr, addr, data, be), $urandom_range(0, 3));
    end

    b2b_test();

`ifdef MEM_BYTE_MASK_EN
    do_req("be_init",  1'b1, 5'd7, 32'hAABBCCDD, 4'hF,    32'hAABBCCDD, 0);
    do_req("be_0101",  1'b1, 5'd7, 32'h11223344, 4'b0101, 32'hAA22CC44, 0);
    do_req("be_read",  1'b0, 5'd7, 32'h0,        4'h0,    32'hAA22CC44, 0);
    do_req("be_none",  1'b1, 5'd7, 32'hFFFFFFFF, 4'h0,    32'hAA22CC44, 0);
    do_req("be_read2", 1'b0, 5'd7, 32'h0,        4'hF,    32'hAA22CC44, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
